// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the memory.
// The slave view is the arbiter's; the master view is the requesters' and the memory's.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              p0_req, p0_we, p0_lock, p0_ack, p0_stall;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata, p0_rdata;
  logic              p1_req, p1_we, p1_lock, p1_ack, p1_stall;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata, p1_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_read, mem_write;

  modport slave (
    input  p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
    output p0_rdata, p0_ack, p0_stall,
    input  p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
    output p1_rdata, p1_ack, p1_stall,
    output mem_addr, mem_wdata, mem_read, mem_write,
    input  mem_rdata
  );

  modport master (
    output p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
    input  p0_rdata, p0_ack, p0_stall,
    output p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
    input  p1_rdata, p1_ack, p1_stall,
    input  mem_addr, mem_wdata, mem_read, mem_write,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory between the CPU
// load/store port (0) and the loader port (1), with a bounded per-port lock.
module dmem_arb_port #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hit,
  input  logic              we,
  input  logic              req,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              stall
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack   <= 1'b0;
      rdata <= '0;
    end else begin
      ack <= hit;
      if (hit && !we) rdata <= mem_rdata;
    end
  end

  assign stall = req & ~ack;
endmodule

module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);
  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, GNT, RSP} state_t;

  state_t                   state, state_nxt;
  logic                     g, g_nxt, last, last_nxt, pick;
  logic [BW-1:0]            burst_cnt, burst_nxt;
  logic [1:0]               req, we, lock, hit, ack, stall;
  logic [1:0][ADDR_W-1:0]   addr;
  logic [1:0][DATA_W-1:0]   wdata, rdata;

  assign req   = {bus.p1_req,   bus.p0_req};
  assign we    = {bus.p1_we,    bus.p0_we};
  assign lock  = {bus.p1_lock,  bus.p0_lock};
  assign addr  = {bus.p1_addr,  bus.p0_addr};
  assign wdata = {bus.p1_wdata, bus.p0_wdata};

  // On a tie the port not served last wins; otherwise the lone requester.
  assign pick = (req[0] & req[1]) ? ~last : req[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      g         <= 1'b0;
      last      <= 1'b1;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      g         <= g_nxt;
      last      <= last_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    g_nxt     = g;
    last_nxt  = last;
    burst_nxt = burst_cnt;
    unique case (state)
      IDLE: if (|req) begin
        state_nxt = GNT;
        g_nxt     = pick;
        burst_nxt = '0;
      end
      GNT: begin
        state_nxt = RSP;
        last_nxt  = g;
      end
      RSP: begin
        if (req[g] && lock[g] && (burst_cnt < BURST_LAST)) begin
          state_nxt = GNT;
          burst_nxt = burst_cnt + BW'(1);
        end else if (|req) begin
          state_nxt = GNT;
          g_nxt     = pick;
          burst_nxt = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_addr  = addr[0];
    bus.mem_wdata = wdata[0];
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    if (state == GNT) begin
      bus.mem_addr  = addr[g];
      bus.mem_wdata = wdata[g];
      bus.mem_read  = ~we[g];
      bus.mem_write = we[g];
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_port
    assign hit[i] = (state == GNT) && (g == 1'(i));
    dmem_arb_port #(.DATA_W(DATA_W)) u_port (
      .clk       (clk),
      .reset     (reset),
      .hit       (hit[i]),
      .we        (we[i]),
      .req       (req[i]),
      .mem_rdata (bus.mem_rdata),
      .ack       (ack[i]),
      .rdata     (rdata[i]),
      .stall     (stall[i])
    );
  end

  assign bus.p0_ack   = ack[0];
  assign bus.p1_ack   = ack[1];
  assign bus.p0_rdata = rdata[0];
  assign bus.p1_rdata = rdata[1];
  assign bus.p0_stall = stall[0];
  assign bus.p1_stall = stall[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, checked
// against a transaction-level scheduler model and a reference memory.
module tb_dmem_arbiter;
  localparam int AW = 32, DW = 32, MB = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(rst_n), .bus(bus.slave));

  // Physical memory behind the arbiter, with a preload port.
  logic [31:0] mem [256];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_a  = '0;
  logic [31:0] pl_d  = '0;
  always @(posedge clk)
    if (pl_en) mem[pl_a] <= pl_d;
    else if (bus.mem_write) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
  assign bus.mem_rdata = mem[bus.mem_addr[7:0]];

  logic        r_req[2], r_we[2], r_lock[2];
  logic [31:0] r_addr[2], r_wd[2];
  assign bus.p0_req = r_req[0];  assign bus.p0_we = r_we[0];  assign bus.p0_lock = r_lock[0];
  assign bus.p0_addr = r_addr[0]; assign bus.p0_wdata = r_wd[0];
  assign bus.p1_req = r_req[1];  assign bus.p1_we = r_we[1];  assign bus.p1_lock = r_lock[1];
  assign bus.p1_addr = r_addr[1]; assign bus.p1_wdata = r_wd[1];

  typedef struct { bit we; bit lock; logic [31:0] addr; logic [31:0] data; } txn_t;
  txn_t q0[$], q1[$];

  // Scheduler model: phase 0 = free, 1 = memory busy for gm, 2 = gm being acked.
  int          phase, bc;
  bit          gm, lastm, cwe;
  logic [7:0]  ca;
  logic [31:0] cd;
  logic [31:0] refmem [256];
  logic [31:0] exp_rd [2];
  bit          ack_e [2];

  int total = 0, fails = 0, cyc = 0, nwr = 0, nrd = 0;
  int ack_port[$], ack_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic txn_t mk(input bit we, input bit lock, input int addr, input logic [31:0] data);
    txn_t t;
    t.we = we; t.lock = lock; t.addr = 32'(addr); t.data = data;
    return t;
  endfunction

  task automatic model_reset();
    phase = 0; bc = 0; gm = 1'b0; lastm = 1'b1; cwe = 1'b0;
    exp_rd[0] = '0; exp_rd[1] = '0;
  endtask

  task automatic present(input int i, input bit v, input txn_t t);
    r_req[i] = v;
    if (v) begin r_we[i] = t.we; r_lock[i] = t.lock; r_addr[i] = t.addr; r_wd[i] = t.data; end
    else r_lock[i] = 1'b0;
  endtask

  task automatic drive();
    txn_t none;
    none = mk(0, 0, 0, 0);
    present(0, q0.size() != 0, (q0.size() != 0) ? q0[0] : none);
    present(1, q1.size() != 0, (q1.size() != 0) ? q1[0] : none);
  endtask

  task automatic grant(input bit p);
    gm = p; cwe = r_we[p]; ca = r_addr[p][7:0]; cd = r_wd[p]; phase = 1;
  endtask

  // Applies the arbitration rules to the inputs presented for the coming edge.
  task automatic decide();
    if (phase == 1) begin
      if (cwe) refmem[ca] = cd; else exp_rd[gm] = refmem[ca];
      lastm = gm; phase = 2;
    end else if (phase == 2 && r_req[gm] && r_lock[gm] && bc < MB - 1) begin
      bc++; grant(gm);
    end else if (r_req[0] || r_req[1]) begin
      bc = 0; grant((r_req[0] && r_req[1]) ? !lastm : r_req[1]);
    end else phase = 0;
  endtask

  task automatic sample();
    @(negedge clk);
    cyc++;
    ack_e[0] = (phase == 2) && !gm;
    ack_e[1] = (phase == 2) && gm;
    chk("p0_ack",    bus.p0_ack,    ack_e[0]);
    chk("p1_ack",    bus.p1_ack,    ack_e[1]);
    chk("p0_rdata",  bus.p0_rdata,  exp_rd[0]);
    chk("p1_rdata",  bus.p1_rdata,  exp_rd[1]);
    chk("p0_stall",  bus.p0_stall,  r_req[0] && !ack_e[0]);
    chk("p1_stall",  bus.p1_stall,  r_req[1] && !ack_e[1]);
    chk("mem_read",  bus.mem_read,  (phase == 1) && !cwe);
    chk("mem_write", bus.mem_write, (phase == 1) && cwe);
    chk("mem_addr",  bus.mem_addr,  (phase == 1) ? r_addr[gm] : r_addr[0]);
    chk("mem_wdata", bus.mem_wdata, (phase == 1) ? r_wd[gm] : r_wd[0]);
    if (bus.p0_ack) begin ack_port.push_back(0); ack_cyc.push_back(cyc); end
    if (bus.p1_ack) begin ack_port.push_back(1); ack_cyc.push_back(cyc); end
    nwr += int'(bus.mem_write);
    nrd += int'(bus.mem_read);
    if (ack_e[0] && q0.size() != 0) void'(q0.pop_front());
    if (ack_e[1] && q1.size() != 0) void'(q1.pop_front());
  endtask

  task automatic cycle();
    drive(); decide(); sample();
  endtask

  task automatic run(input int maxc);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || phase != 0) && n < maxc) begin cycle(); n++; end
    chk("timeout", 32'(n < maxc), 1);
  endtask

  task automatic clear_log();
    ack_port.delete(); ack_cyc.delete(); nwr = 0; nrd = 0;
  endtask

  task automatic chk_order(input string tag, input int expo[6]);
    chk({tag, "_cnt"}, ack_port.size(), 6);
    for (int i = 0; i < ack_port.size() && i < 6; i++) chk(tag, ack_port[i], expo[i]);
  endtask

  initial begin
    int s;
    int ord_alt[6]  = '{0, 1, 0, 1, 0, 1};
    int ord_lock[6] = '{1, 1, 1, 1, 0, 1};
    for (int i = 0; i < 2; i++) begin
      r_req[i] = 0; r_we[i] = 0; r_lock[i] = 0; r_addr[i] = '0; r_wd[i] = '0;
    end
    model_reset();
    for (int a = 0; a < 256; a++) refmem[a] = (a < 64) ? $urandom : 32'h0;
    refmem[8'h10] = 32'hDEADBEEF;
    refmem[8'h30] = 32'hA5A5A5A5;
    for (int a = 0; a < 256; a++) begin
      @(negedge clk); pl_en = 1'b1; pl_a = a[7:0]; pl_d = refmem[a];
    end
    @(negedge clk); pl_en = 1'b0;
    chk("rst_p0_ack",   bus.p0_ack,    0);
    chk("rst_p1_ack",   bus.p1_ack,    0);
    chk("rst_p0_rdata", bus.p0_rdata,  0);
    chk("rst_p1_rdata", bus.p1_rdata,  0);
    chk("rst_mem_rd",   bus.mem_read,  0);
    chk("rst_mem_wr",   bus.mem_write, 0);
    rst_n = 1'b1;
    sample();

    // Single read from IDLE
    clear_log();
    q0.push_back(mk(0, 0, 'h10, 0));
    s = cyc;
    run(20);
    chk("rd_lat", (ack_cyc.size() != 0) ? 32'(ack_cyc[0] - s) : 32'hFFFF_FFFF, 2);
    chk("rd_data", bus.p0_rdata, 32'hDEADBEEF);
    chk("rd_nrd", nrd, 1);

    // Port 1 write then read back
    clear_log();
    q1.push_back(mk(1, 0, 'h20, 32'h12345678));
    q1.push_back(mk(0, 0, 'h20, 0));
    run(20);
    chk("wr_rdback", bus.p1_rdata, 32'h12345678);
    chk("wr_p0keep", bus.p0_rdata, 32'hDEADBEEF);
    chk("wr_nwr", nwr, 1);
    chk("wr_nrd", nrd, 1);

    // Contention without locks alternates
    clear_log();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(mk(0, 0, i, 0));
      q1.push_back(mk(0, 0, 8 + i, 0));
    end
    run(40);
    chk_order("cont_order", ord_alt);
    for (int i = 1; i < ack_cyc.size(); i++) chk("cont_gap", ack_cyc[i] - ack_cyc[i-1], 2);

    // Locked burst from port 1 is capped at MAX_BURST
    clear_log();
    for (int i = 0; i < 5; i++) q1.push_back(mk(i[0], 1, 40 + i, $urandom));
    cycle();
    q0.push_back(mk(0, 0, 'h10, 0));
    run(40);
    chk_order("lock_order", ord_lock);

    // Back-to-back on a single port
    clear_log();
    for (int i = 0; i < 3; i++) q0.push_back(mk(0, 0, 20 + i, 0));
    s = cyc;
    run(20);
    chk("b2b_cnt", ack_cyc.size(), 3);
    for (int i = 0; i < ack_cyc.size(); i++) chk("b2b_cyc", ack_cyc[i] - s, 2 * (i + 1));

    // Reset during the grant cycle of a write
    q0.push_back(mk(1, 0, 'h30, 32'h11111111));
    cycle();
    chk("rst_in_gnt", bus.mem_write, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_p0_ack",   bus.p0_ack,    0);
    chk("mid_p1_ack",   bus.p1_ack,    0);
    chk("mid_p0_rdata", bus.p0_rdata,  0);
    chk("mid_p1_rdata", bus.p1_rdata,  0);
    chk("mid_mem_wr",   bus.mem_write, 0);
    chk("mid_mem_rd",   bus.mem_read,  0);
    q0.delete(); q1.delete();
    r_req[0] = 0; r_req[1] = 0;
    model_reset();
    @(negedge clk);
    chk("mid_nowrite", mem[8'h30], 32'hA5A5A5A5);
    rst_n = 1'b1;
    clear_log();
    q0.push_back(mk(0, 0, 'h31, 0));
    q1.push_back(mk(0, 0, 'h32, 0));
    run(20);
    chk("post_rst_first", (ack_port.size() != 0) ? 32'(ack_port[0]) : 32'hFFFF_FFFF, 0);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      if (q0.size() < 2 && $urandom_range(0, 2) == 0)
        q0.push_back(mk($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, $urandom_range(0, 63), $urandom));
      if (q1.size() < 2 && $urandom_range(0, 2) == 0)
        q1.push_back(mk($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, $urandom_range(0, 63), $urandom));
      cycle();
    end
    run(100);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter that shares the single-ported data memory between the processor load/store path (port 0) and the program/debug loader (port 1).
- Serialises transactions with a req/ack handshake and round-robin fairness.
- A per-port lock lets one requester hold the memory for a bounded burst.
- Generates a stall signal for the processor while its access is pending.

Parameters:
- ADDR_W, 32, address width of both ports and of the memory.
- DATA_W, 32, data width.
- MAX_BURST, 4, maximum consecutive transactions granted to one locked port (≥1).

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- p0_req  in  1  port 0 request; held with addr/we/wdata stable until p0_ack
- p0_we  in  1  port 0: 1=write, 0=read
- p0_lock  in  1  port 0 requests regrant after the current transaction
- p0_addr  in  ADDR_W  port 0 address
- p0_wdata  in  DATA_W  port 0 write data
- p0_rdata  out  DATA_W  port 0 read data, valid in the p0_ack cycle
- p0_ack  out  1  port 0 one-cycle completion pulse
- p0_stall  out  1  p0_req & ~p0_ack, combinational
- p1_req, p1_we, p1_lock, p1_addr, p1_wdata, p1_rdata, p1_ack  same as port 0, for port 1
- mem_addr  out  ADDR_W  address to the data memory
- mem_wdata  out  DATA_W  write data to the data memory
- mem_read  out  1  read strobe
- mem_write  out  1  write strobe; memory writes on the clock edge
- mem_rdata  in  DATA_W  combinational memory read data

Behaviour:
- States:
  - IDLE: no grant.
  - GNT: memory driven for the granted port `g`.
  - RSP: ack to `g`; next grant decided here.
- Registers:
  - state
  - g (1 bit)
  - last (last served port)
  - burst_cnt (width clog2(MAX_BURST)+1)
  - p0_rdata, p1_rdata, p0_ack, p1_ack
- Reset (reset=0, async), applied immediately regardless of state:
  - state=IDLE, g=0, last=1 (port 0 wins the first tie), burst_cnt=0.
  - Both rdata outputs = 0, both acks = 0.
  - mem_read=mem_write=0.
  - Any in-flight transaction is dropped with no ack. A write in its GNT cycle does not occur if reset asserts before the edge.
- Arbitration function A(last): if both req, pick ~last; else pick the single requester; none → IDLE.
- IDLE: if any req → GNT with g=A(last), burst_cnt=0.
- GNT (exactly 1 cycle):
  - mem_addr/mem_wdata = granted port's addr/wdata.
  - mem_read = ~we_g, mem_write = we_g.
  - At the clock edge: if read, pg_rdata <= mem_rdata; pg_ack <= 1; last <= g; → RSP.
- RSP:
  - pg_ack=1 for exactly this cycle; the requester may present its next request in this same cycle.
  - Lock rule: if req_g & lock_g & (burst_cnt < MAX_BURST-1) → GNT with same g, burst_cnt+1.
  - Else if any req → GNT with g=A(last), burst_cnt=0. This gives an unlocked port strict alternation under contention, and back-to-back regrant when the other port is idle.
  - Else → IDLE.
- Outside GNT: mem_read=mem_write=0; mem_addr/mem_wdata = port 0 values.
- Latency: request seen in IDLE → ack 2 cycles later. Sustained throughput is 1 transaction per 2 cycles.
- rdata holds its last captured value; a write does not modify rdata.
- Protocol violations:
  - Dropping req while in GNT: the transaction still completes and acks.
  - Changing addr/wdata during GNT: the value sampled at the edge is used.
- Worst-case wait for an unlocked port under contention: MAX_BURST transactions of the other port.

Test Plan:
- Single read: mem[0x10]=0xDEADBEEF; p0 read 0x10 from IDLE → mem_read=1 only in cycle +1; p0_ack pulses at cycle +2 with p0_rdata=0xDEADBEEF; p0_stall high for 2 cycles.
- Write then read: p1 write 0x20←0x12345678, then p1 read 0x20 → exactly one mem_write pulse; read returns 0x12345678; p0_rdata unchanged.
- Contention: both ports hold req continuously (locks=0) for 6 transactions → grant order 0,1,0,1,0,1; ack pulses every 2 cycles.
- Lock cap: p1_lock=1 with p1_req and p0_req held, MAX_BURST=4, p1 first → 4 consecutive p1 acks, then p0 granted; burst_cnt returns to 0.
- Back-to-back same port: only p0 requesting, 3 reads with req kept high through RSP → acks at cycles 2,4,6, no IDLE cycle between.
- Reset mid-operation: pull reset low during GNT of a p0 write to 0x30 → no mem write, no ack, all outputs 0 immediately; after release, first tied request goes to port 0.
